// File: rtl/trace_debugger_pkg.sv
// trace_debugger_pkg: shared trace entry type and field widths for the retire serializer.
// Entries carry the widest supported XLEN/CAUSELEN; users truncate to their own widths.
package trace_debugger_pkg;
    localparam int PRIVLEN      = 3;
    localparam int ILEN         = 32;
    localparam int MAX_XLEN     = 64;
    localparam int MAX_CAUSELEN = 16;

    typedef struct packed {
        logic                    iexception;
        logic                    interrupt;
        logic [MAX_CAUSELEN-1:0] cause;
        logic [MAX_XLEN-1:0]     tval;
        logic [PRIVLEN-1:0]      priv;
        logic [MAX_XLEN-1:0]     iaddr;
        logic [ILEN-1:0]         instr;
        logic                    compressed;
    } trace_entry_t;
endpackage

// File: rtl/trace_retire_fifo.sv
// trace_retire_fifo: circular buffer taking up to NRET in-order entries per cycle, one out.
module trace_retire_fifo
    import trace_debugger_pkg::*;
#(
    parameter int NRET  = 2,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH),
    localparam int FW   = $clog2(DEPTH) + 1,
    localparam int KW   = $clog2(NRET + 1)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          wr_en,
    input  logic [KW-1:0] wr_cnt,
    input  trace_entry_t  wr_data [NRET],
    input  logic          rd_en,
    output trace_entry_t  head,
    output logic [FW-1:0] fill
);
    trace_entry_t  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;

    // Storage is deliberately unreset; pointers and fill define what is valid.
    always_ff @(posedge clk_i)
        if (wr_en)
            for (int i = 0; i < NRET; i++)
                if (KW'(i) < wr_cnt) mem[wr_ptr + AW'(i)] <= wr_data[i];

    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(wr_cnt);
            if (rd_en) rd_ptr <= rd_ptr + AW'(1);
            fill <= fill + (wr_en ? FW'(wr_cnt) : '0) - FW'(rd_en);
        end

    assign head = mem[rd_ptr];
endmodule

// File: rtl/trace_retire_serializer.sv
// trace_retire_serializer: compacts NRET retirement lanes into one in-order trace stream.
// Define TRACE_DROP_CNT_EN to add the saturating dropped-instruction counter drop_cnt_o.
module trace_retire_serializer
    import trace_debugger_pkg::*;
#(
    parameter int NRET     = 2,
    parameter int XLEN     = 32,
    parameter int CAUSELEN = 5,
    parameter int DEPTH    = 8,
    localparam int FW      = $clog2(DEPTH) + 1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NRET-1:0]          ivalid_i,
    input  logic [NRET-1:0]          iexception_i,
    input  logic [NRET-1:0]          interrupt_i,
    input  logic [NRET-1:0]          compressed_i,
    input  logic [NRET*CAUSELEN-1:0] cause_i,
    input  logic [NRET*XLEN-1:0]     tval_i,
    input  logic [NRET*XLEN-1:0]     iaddr_i,
    input  logic [NRET*PRIVLEN-1:0]  priv_i,
    input  logic [NRET*ILEN-1:0]     instr_i,
    input  logic                     clear_overflow_i,
    output logic                     valid_o,
    input  logic                     ready_i,
    output logic                     iexception_o,
    output logic                     interrupt_o,
    output logic                     compressed_o,
    output logic [CAUSELEN-1:0]      cause_o,
    output logic [XLEN-1:0]          tval_o,
    output logic [XLEN-1:0]          iaddr_o,
    output logic [PRIVLEN-1:0]       priv_o,
    output logic [ILEN-1:0]          instr_o,
    output logic [FW-1:0]            fill_o,
    output logic                     overflow_o
`ifdef TRACE_DROP_CNT_EN
    ,
    output logic [15:0]              drop_cnt_o
`endif
);
    localparam int KW = $clog2(NRET + 1);
    localparam int CW = FW + 1;

    trace_entry_t    lane_e  [NRET];
    trace_entry_t    wr_data [NRET];
    trace_entry_t    head;
    logic [KW-1:0]   pos [NRET];
    logic [NRET-1:0] acc;
    logic [KW-1:0]   k;
    logic            blocked, pop, fits, wr_en, drop, overflow_q;

    // Lanes above the first excepting lane are discarded; survivors pack into slots 0..k-1.
    always_comb begin
        k = '0;
        blocked = 1'b0;
        for (int n = 0; n < NRET; n++) begin
            lane_e[n] = '{
                iexception: iexception_i[n],
                interrupt:  interrupt_i[n],
                cause:      MAX_CAUSELEN'(cause_i[n*CAUSELEN +: CAUSELEN]),
                tval:       MAX_XLEN'(tval_i[n*XLEN +: XLEN]),
                priv:       priv_i[n*PRIVLEN +: PRIVLEN],
                iaddr:      MAX_XLEN'(iaddr_i[n*XLEN +: XLEN]),
                instr:      instr_i[n*ILEN +: ILEN],
                compressed: compressed_i[n]
            };
            acc[n] = ivalid_i[n] & ~blocked;
            pos[n] = k;
            k = k + KW'(acc[n]);
            blocked = blocked | (ivalid_i[n] & iexception_i[n]);
        end
        for (int j = 0; j < NRET; j++) begin
            wr_data[j] = '0;
            for (int n = j; n < NRET; n++)
                if (acc[n] && pos[n] == KW'(j)) wr_data[j] = lane_e[n];
        end
    end

    // A pop in the same cycle frees one slot for the incoming group.
    assign pop   = valid_o & ready_i;
    assign fits  = CW'(fill_o) + CW'(k) <= CW'(DEPTH) + CW'(pop);
    assign wr_en = (k != '0) && fits;
    assign drop  = (k != '0) && !fits;

    trace_retire_fifo #(.NRET(NRET), .DEPTH(DEPTH)) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .wr_en   (wr_en),
        .wr_cnt  (k),
        .wr_data (wr_data),
        .rd_en   (pop),
        .head    (head),
        .fill    (fill_o)
    );

    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) overflow_q <= 1'b0;
        else       overflow_q <= drop | (overflow_q & ~clear_overflow_i);

    assign overflow_o   = overflow_q;
    assign valid_o      = fill_o != '0;
    assign iexception_o = valid_o & head.iexception;
    assign interrupt_o  = valid_o & head.interrupt;
    assign compressed_o = valid_o & head.compressed;
    assign cause_o      = valid_o ? CAUSELEN'(head.cause) : '0;
    assign tval_o       = valid_o ? XLEN'(head.tval) : '0;
    assign iaddr_o      = valid_o ? XLEN'(head.iaddr) : '0;
    assign priv_o       = valid_o ? head.priv : '0;
    assign instr_o      = valid_o ? head.instr : '0;

`ifdef TRACE_DROP_CNT_EN
    logic [15:0] drop_cnt;

    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i)                 drop_cnt <= '0;
        else if (clear_overflow_i) drop_cnt <= drop ? 16'(k) : '0;
        else if (drop)             drop_cnt <= (drop_cnt > 16'hFFFF - 16'(k)) ? 16'hFFFF : drop_cnt + 16'(k);

    assign drop_cnt_o = drop_cnt;
`endif
endmodule

// File: tb/tb_trace_retire_serializer.sv
// tb_trace_retire_serializer: directed checks of lane compaction, ordering, overflow and reset.
module tb_trace_retire_serializer;
    localparam int NRET = 2, XLEN = 32, CAUSELEN = 5, DEPTH = 8;

    logic clk = 1'b0, rst_i = 1'b1;
    logic [NRET-1:0] ivalid_i, iexception_i, interrupt_i, compressed_i;
    logic [NRET*CAUSELEN-1:0] cause_i;
    logic [NRET*XLEN-1:0] tval_i, iaddr_i;
    logic [NRET*3-1:0] priv_i;
    logic [NRET*32-1:0] instr_i;
    logic clear_overflow_i, ready_i;
    logic valid_o, iexception_o, interrupt_o, compressed_o, overflow_o;
    logic [CAUSELEN-1:0] cause_o;
    logic [XLEN-1:0] tval_o, iaddr_o;
    logic [2:0] priv_o;
    logic [31:0] instr_o;
    logic [$clog2(DEPTH):0] fill_o;
`ifdef TRACE_DROP_CNT_EN
    logic [15:0] drop_cnt_o;
`endif

    int n_chk = 0, n_fail = 0;
    logic [31:0] q[$];

    always #5 clk = ~clk;

    trace_retire_serializer #(.NRET(NRET), .XLEN(XLEN), .CAUSELEN(CAUSELEN), .DEPTH(DEPTH)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .ivalid_i(ivalid_i), .iexception_i(iexception_i), .interrupt_i(interrupt_i),
        .compressed_i(compressed_i), .cause_i(cause_i), .tval_i(tval_i), .iaddr_i(iaddr_i),
        .priv_i(priv_i), .instr_i(instr_i), .clear_overflow_i(clear_overflow_i),
        .valid_o(valid_o), .ready_i(ready_i), .iexception_o(iexception_o),
        .interrupt_o(interrupt_o), .compressed_o(compressed_o), .cause_o(cause_o),
        .tval_o(tval_o), .iaddr_o(iaddr_o), .priv_o(priv_o), .instr_o(instr_o),
        .fill_o(fill_o), .overflow_o(overflow_o)
`ifdef TRACE_DROP_CNT_EN
        , .drop_cnt_o(drop_cnt_o)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ivalid_i = '0; iexception_i = '0; interrupt_i = '0; compressed_i = '0;
        cause_i = '0; tval_i = '0; iaddr_i = '0; priv_i = '0; instr_i = '0;
    endtask

    task automatic lane(input int n, input logic [31:0] addr, input logic exc = 1'b0,
                        input logic [4:0] cause = 5'd0);
        ivalid_i[n] = 1'b1;
        iexception_i[n] = exc;
        cause_i[n*5 +: 5] = cause;
        iaddr_i[n*32 +: 32] = addr;
        tval_i[n*32 +: 32] = addr + 32'd1;
        instr_i[n*32 +: 32] = addr ^ 32'hABCD0000;
        priv_i[n*3 +: 3] = 3'd3;
    endtask

    initial begin
        idle();
        ready_i = 1'b0;
        clear_overflow_i = 1'b0;
        step();
        step();
        chk("rst_valid", valid_o, 0);
        chk("rst_fill", fill_o, 0);
        chk("rst_ovf", overflow_o, 0);
        chk("rst_iaddr", iaddr_o, 0);
        rst_i = 1'b0;

        // two lanes, drained back-to-back
        ready_i = 1'b1;
        lane(0, 32'h100); lane(1, 32'h104);
        compressed_i[0] = 1'b1; interrupt_i[1] = 1'b1;
        step(); idle();
        chk("pair_valid", valid_o, 1);
        chk("pair_fill0", fill_o, 2);
        chk("pair_addr0", iaddr_o, 32'h100);
        chk("pair_instr0", instr_o, 32'hABCD0100);
        chk("pair_tval0", tval_o, 32'h101);
        chk("pair_priv0", priv_o, 3);
        chk("pair_comp0", compressed_o, 1);
        chk("pair_intr0", interrupt_o, 0);
        step();
        chk("pair_fill1", fill_o, 1);
        chk("pair_addr1", iaddr_o, 32'h104);
        chk("pair_intr1", interrupt_o, 1);
        chk("pair_comp1", compressed_o, 0);
        step();
        chk("pair_empty", valid_o, 0);
        chk("pair_fill2", fill_o, 0);
        chk("pair_zero_addr", iaddr_o, 0);
        chk("pair_zero_instr", instr_o, 0);

        // lane 1 only; an invalid lane's exception flag must not truncate; stall holds head
        ready_i = 1'b0;
        iexception_i[0] = 1'b1;
        lane(1, 32'h200);
        step(); idle();
        chk("single_fill", fill_o, 1);
        chk("single_addr", iaddr_o, 32'h200);
        chk("single_exc", iexception_o, 0);
        step();
        chk("stall_addr", iaddr_o, 32'h200);
        chk("stall_fill", fill_o, 1);
        ready_i = 1'b1;
        step();
        chk("single_drain", fill_o, 0);

        // exception on lane 0 drops lane 1; exception on lane 1 keeps both
        ready_i = 1'b0;
        lane(0, 32'h300, 1'b1, 5'd2); lane(1, 32'h304);
        step(); idle();
        chk("exc0_fill", fill_o, 1);
        chk("exc0_flag", iexception_o, 1);
        chk("exc0_cause", cause_o, 2);
        chk("exc0_addr", iaddr_o, 32'h300);
        lane(0, 32'h340); lane(1, 32'h344, 1'b1, 5'd7);
        step(); idle();
        chk("exc1_fill", fill_o, 3);
        ready_i = 1'b1;
        chk("exc_head", iaddr_o, 32'h300);
        step();
        chk("exc1_addr0", iaddr_o, 32'h340);
        chk("exc1_flag0", iexception_o, 0);
        step();
        chk("exc1_addr1", iaddr_o, 32'h344);
        chk("exc1_flag1", iexception_o, 1);
        chk("exc1_cause1", cause_o, 7);
        step();
        chk("exc_drain", fill_o, 0);

        // fill to DEPTH with consumer stalled; fifth group dropped whole
        ready_i = 1'b0;
        for (int c = 0; c < 5; c++) begin
            lane(0, 32'h400 + 32'(8 * c)); lane(1, 32'h404 + 32'(8 * c));
            step();
            chk("full_fill", fill_o, (c < 4) ? 2 * c + 2 : 8);
            chk("full_ovf", overflow_o, c == 4);
        end
        idle();
`ifdef TRACE_DROP_CNT_EN
        chk("full_dropcnt", drop_cnt_o, 2);
`endif
        clear_overflow_i = 1'b1;
        step();
        clear_overflow_i = 1'b0;
        chk("clear_ovf", overflow_o, 0);
`ifdef TRACE_DROP_CNT_EN
        chk("clear_dropcnt", drop_cnt_o, 0);
`endif
        ready_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("full_order", iaddr_o, 32'h400 + 32'(4 * i));
            step();
        end
        chk("full_drain", fill_o, 0);
        chk("full_drain_valid", valid_o, 0);

        // fill 7: 2-lane group dropped without pop, accepted with pop credit
        ready_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            lane(0, 32'h500 + 32'(8 * c)); lane(1, 32'h504 + 32'(8 * c));
            step();
        end
        idle(); lane(0, 32'h518);
        step(); idle();
        chk("seven_fill", fill_o, 7);
        lane(0, 32'h51C); lane(1, 32'h520);
        step(); idle();
        chk("seven_nopartial", fill_o, 7);
        chk("seven_ovf", overflow_o, 1);
        clear_overflow_i = 1'b1;
        step();
        clear_overflow_i = 1'b0;
        chk("seven_clear", overflow_o, 0);
        ready_i = 1'b1;
        lane(0, 32'h51C); lane(1, 32'h520);
        step(); idle();
        ready_i = 1'b0;
        chk("credit_fill", fill_o, 8);
        chk("credit_ovf", overflow_o, 0);
        ready_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("credit_order", iaddr_o, 32'h504 + 32'(4 * i));
            step();
        end
        chk("credit_drain", fill_o, 0);

        // asynchronous reset mid-stream, inputs ignored while held
        ready_i = 1'b0;
        lane(0, 32'h700); lane(1, 32'h704); step();
        lane(0, 32'h708); lane(1, 32'h70C); step();
        idle(); lane(0, 32'h710); step(); idle();
        chk("pre_rst_fill", fill_o, 5);
        #3 rst_i = 1'b1;
        lane(0, 32'h7F0);
        #1;
        chk("async_valid", valid_o, 0);
        chk("async_fill", fill_o, 0);
        chk("async_addr", iaddr_o, 0);
        step(); idle();
        chk("held_fill", fill_o, 0);
        rst_i = 1'b0;

        // 20 post-reset writes through the wrapping buffer
        ready_i = 1'b1;
        for (int c = 0; c < 24; c++) begin
            chk("wrap_fill", fill_o, q.size());
            chk("wrap_valid", valid_o, q.size() != 0);
            if (q.size() != 0) begin
                chk("wrap_order", iaddr_o, q[0]);
                void'(q.pop_front());
            end
            idle();
            if (c < 20 && c % 2 == 0) begin
                lane(0, 32'h600 + 32'(4 * c)); lane(1, 32'h604 + 32'(4 * c));
                q.push_back(32'h600 + 32'(4 * c));
                q.push_back(32'h604 + 32'(4 * c));
            end
            step();
        end
        chk("wrap_end_fill", fill_o, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/trace_retire_serializer.md
TRACE_RETIRE_SERIALIZER -- requirements
Module: trace_retire_serializer

Interface
REQ-001 Parameter NRET, default 2, number of retirement lanes per cycle (1..4).
REQ-002 Parameter XLEN, default 32, address/tval width.
REQ-003 Parameter CAUSELEN, default 5, cause width.
REQ-004 Parameter DEPTH, default 8, buffer entries; power of two, DEPTH >= NRET.
REQ-005 clk_i  in  1  sole clock, rising edge.
REQ-006 rst_i  in  1  reset, asynchronous, active-high.
REQ-007 ivalid_i  in  NRET  lane retired an instruction.
REQ-008 iexception_i, interrupt_i, compressed_i  in  NRET each  per-lane flags.
REQ-009 cause_i  in  NRET*CAUSELEN; tval_i, iaddr_i  in  NRET*XLEN; priv_i  in  NRET*3; instr_i  in  NRET*32  per-lane fields, lane n at slice n.
REQ-010 clear_overflow_i  in  1  clears sticky overflow.
REQ-011 valid_o  out  1  head entry available; ready_i  in  1  consumer accepts.
REQ-012 iexception_o, interrupt_o, compressed_o  out  1; cause_o  CAUSELEN; tval_o, iaddr_o  XLEN; priv_o  3; instr_o  32  head entry fields.
REQ-013 fill_o  out  $clog2(DEPTH)+1  entries stored.
REQ-014 overflow_o  out  1  sticky drop flag.
REQ-015 drop_cnt_o  out  16  dropped-instruction count (only with TRACE_DROP_CNT_EN).

Function
REQ-016 Each cycle, accepted set = valid lanes in ascending lane order, truncated after the lowest lane with ivalid_i&iexception_i; K = size of set (0..NRET).
REQ-017 Write SHALL occur iff K>0 and K <= DEPTH - fill + P, P = 1 if valid_o&ready_i this cycle else 0.
REQ-018 On write, lowest accepted lane SHALL occupy the first free slot, remaining lanes following in order; write pointer advances by K modulo DEPTH.
REQ-019 If K>0 and write condition fails, the whole group SHALL be dropped (no partial write) and overflow_o set from next cycle.
REQ-020 overflow_o SHALL hold until clear_overflow_i; simultaneous drop and clear leaves overflow_o = 1.
REQ-021 valid_o = (fill != 0); data outputs reflect head entry; all data outputs SHALL be 0 while valid_o = 0.
REQ-022 Pop on valid_o&ready_i; read pointer advances by 1 modulo DEPTH.
REQ-023 Latency: instruction written in cycle t visible at valid_o in cycle t+1 earliest.
REQ-024 While valid_o&!ready_i, all outputs SHALL remain stable.
REQ-025 fill_o next = fill + (written ? K : 0) - P; never exceeds DEPTH.
REQ-026 Output order SHALL equal program order across cycles and lanes.

Reset
REQ-027 rst_i assertion SHALL immediately clear pointers, fill_o, overflow_o, drop_cnt_o and force valid_o and all data outputs to 0.
REQ-028 Buffer storage is not reset; entries in flight at reset are discarded.
REQ-029 Inputs during reset are ignored; first write possible in first cycle after deassertion.

Configuration
REQ-030 Macro TRACE_DROP_CNT_EN defined: drop_cnt_o present; on drop adds K, saturating at 16'hFFFF; clear_overflow_i zeroes it, same-cycle drop yields K.
REQ-031 Macro undefined: drop_cnt_o port and counter logic absent; all other behaviour identical.

Structure
REQ-032 Package trace_debugger_pkg SHALL hold trace_entry_t (iexception, interrupt, cause, tval, priv, iaddr, instr, compressed), PRIVLEN = 3, ILEN = 32.
REQ-033 Storage SHALL be sub-module trace_retire_fifo (NRET-write, 1-read circular buffer, modulo pointers, fill counter); lane compaction and overflow logic stay in the top.

Verification
REQ-034 NRET=2, DEPTH=8: lanes 0,1 valid iaddr 0x100, 0x104, ready_i=1 -> valid_o next cycle, 0x100 then 0x104 on consecutive cycles, fill_o 2,1,0.
REQ-035 Lane 0 invalid, lane 1 valid iaddr 0x200 -> single entry 0x200, fill_o = 1.
REQ-036 Lane 0 iexception_i=1 cause 2, lane 1 valid -> only lane 0 stored, iexception_o=1, cause_o=2, fill_o=1.
REQ-037 ready_i=0, 5 cycles of 2 valid lanes -> fill_o 8 after 4 cycles, 5th group dropped, overflow_o=1, drop_cnt_o=2 (macro on); clear_overflow_i -> both 0.
REQ-038 fill=7, ready_i=1, 2 lanes valid -> write accepted (pop credited), fill_o = 8, no overflow.
REQ-039 rst_i asserted with fill_o=5 mid-stream -> valid_o=0, fill_o=0 immediately; wrap-around ordering correct over 20 post-reset writes.
